note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_seq_pkg.sv | 46 ++++
 rtl/melody_rom.sv | 18 +
 rtl/note_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: FSM encoding, melody step layout,
// one-hot layer/note constants and default timing dividers.
package note_seq_pkg;

  localparam int LAYER_W   = 3;
  localparam int NOTE_W    = 4;
  localparam int DUR_W     = 4;
  localparam int STEP_W    = LAYER_W + NOTE_W + DUR_W;
  localparam int ADDR_W    = 4;
  localparam int NUM_STEPS = 16;
  localparam int CNT_W     = 24;

  localparam int DEFAULT_BEAT_DIV = 12500000;
  localparam int DEFAULT_GAP_DIV  = 2500000;

  localparam logic [ADDR_W-1:0] LAST_STEP = 4'(NUM_STEPS - 1);

  localparam logic [LAYER_W-1:0] LAYER_OFF  = 3'b000;
  localparam logic [LAYER_W-1:0] LAYER_LOW  = 3'b001;
  localparam logic [LAYER_W-1:0] LAYER_MID  = 3'b010;
  localparam logic [LAYER_W-1:0] LAYER_HIGH = 3'b100;

  localparam logic [NOTE_W-1:0] NOTE_OFF = 4'b0000;
  localparam logic [NOTE_W-1:0] NOTE_0   = 4'b0001;
  localparam logic [NOTE_W-1:0] NOTE_1   = 4'b0010;
  localparam logic [NOTE_W-1:0] NOTE_2   = 4'b0100;
  localparam logic [NOTE_W-1:0] NOTE_3   = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP,
    S_HOLD
  } seq_state_e;

  typedef struct packed {
    logic [LAYER_W-1:0] layer;
    logic [NOTE_W-1:0]  note;
    logic [DUR_W-1:0]   dur;
  } step_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Combinational 16-entry melody table; a zero duration marks the end of the tune.
module melody_rom
  import note_seq_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [STEP_W-1:0] step
);

  always_comb begin
    step = '0;
    case (addr)
      4'd0:    step = {LAYER_LOW, NOTE_0, 4'd2};
      4'd1:    step = {LAYER_MID, NOTE_3, 4'd1};
      default: step = '0;
    endcase
  end

endmodule

// File: rtl/note_sequencer.sv
// Melody sequencer with live-key override. Define SEQ_LOOP_EN to replay the
// melody from step 0 instead of returning to IDLE when it ends.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int BEAT_DIV = DEFAULT_BEAT_DIV,
  parameter int GAP_DIV  = DEFAULT_GAP_DIV
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] key_layer,
  input  logic [3:0] key_note,
  output logic [2:0] state,
  output logic [3:0] note,
  output logic       busy,
  output logic [3:0] step_idx,
  output logic       live_active
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_DIV - 1);

  seq_state_e         fsm_q, fsm_d;
  seq_state_e         ret_q, ret_d;
  logic [ADDR_W-1:0]  step_idx_q, step_idx_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
  logic               arm_q, arm_d;
  logic [LAYER_W-1:0] state_q, state_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic               busy_q, busy_d;
  logic               live_active_q, live_active_d;

  logic               live_valid;
  logic [ADDR_W-1:0]  nxt_addr;
  step_t              cur_step;
  step_t              nxt_step;
  step_t              sel_step;

  assign live_valid = is_onehot4(key_note) && is_onehot4({1'b0, key_layer});
  assign nxt_addr   = step_idx_q + 4'd1;

  melody_rom u_cur_rom (.addr(step_idx_q), .step(cur_step));
  melody_rom u_nxt_rom (.addr(nxt_addr),   .step(nxt_step));

`ifdef SEQ_LOOP_EN
  step_t first_step;
  melody_rom u_first_rom (.addr(4'd0), .step(first_step));
`endif

  // A live key pauses playback in HOLD with the counters as they would have
  // been after this cycle, so releasing the key resumes exactly where it left.
  always_comb begin
    fsm_d      = fsm_q;
    ret_d      = ret_q;
    step_idx_d = step_idx_q;
    beat_cnt_d = beat_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    arm_d      = arm_q | ~start;
    sel_step   = cur_step;

    case (fsm_q)
      S_IDLE: begin
        if (start && !stop && arm_q && cur_step.dur != '0) begin
          fsm_d      = S_PLAY;
          step_idx_d = '0;
          beat_cnt_d = '0;
          dur_cnt_d  = '0;
        end
      end
      S_PLAY: begin
        if (beat_cnt_q == BEAT_LAST) begin
          beat_cnt_d = '0;
          if (dur_cnt_q == cur_step.dur - 4'd1) begin
            fsm_d     = S_GAP;
            dur_cnt_d = '0;
          end else begin
            dur_cnt_d = dur_cnt_q + 4'd1;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 24'd1;
        end
      end
      S_GAP: begin
        if (beat_cnt_q == GAP_LAST) begin
          beat_cnt_d = '0;
          if (step_idx_q == LAST_STEP || nxt_step.dur == '0) begin
            step_idx_d = '0;
`ifdef SEQ_LOOP_EN
            fsm_d    = (first_step.dur != '0) ? S_PLAY : S_IDLE;
            sel_step = first_step;
`else
            fsm_d = S_IDLE;
            arm_d = ~start;
`endif
          end else begin
            fsm_d      = S_PLAY;
            step_idx_d = step_idx_q + 4'd1;
            sel_step   = nxt_step;
          end
        end else begin
          beat_cnt_d = beat_cnt_q + 24'd1;
        end
      end
      S_HOLD: begin
        if (!live_valid) begin
          fsm_d = ret_q;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    if (live_valid && fsm_q != S_IDLE && (fsm_d == S_PLAY || fsm_d == S_GAP)) begin
      ret_d = fsm_d;
      fsm_d = S_HOLD;
    end

    if (stop && fsm_q != S_IDLE) begin
      fsm_d      = S_IDLE;
      step_idx_d = '0;
      beat_cnt_d = '0;
      dur_cnt_d  = '0;
    end

    // Live keys only show in IDLE once the FSM was already idle; the cycle
    // that enters IDLE from playback is always silent.
    state_d       = LAYER_OFF;
    note_d        = NOTE_OFF;
    live_active_d = 1'b0;
    case (fsm_d)
      S_PLAY: begin
        state_d = sel_step.layer;
        note_d  = sel_step.note;
      end
      S_GAP: begin
        state_d = sel_step.layer;
      end
      S_HOLD: begin
        state_d       = key_layer;
        note_d        = key_note;
        live_active_d = 1'b1;
      end
      default: begin
        if (fsm_q == S_IDLE && live_valid) begin
          state_d       = key_layer;
          note_d        = key_note;
          live_active_d = 1'b1;
        end
      end
    endcase
    busy_d = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= S_IDLE;
      ret_q         <= S_IDLE;
      step_idx_q    <= '0;
      beat_cnt_q    <= '0;
      dur_cnt_q     <= '0;
      arm_q         <= 1'b1;
      state_q       <= LAYER_OFF;
      note_q        <= NOTE_OFF;
      busy_q        <= 1'b0;
      live_active_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      ret_q         <= ret_d;
      step_idx_q    <= step_idx_d;
      beat_cnt_q    <= beat_cnt_d;
      dur_cnt_q     <= dur_cnt_d;
      arm_q         <= arm_d;
      state_q       <= state_d;
      note_q        <= note_d;
      busy_q        <= busy_d;
      live_active_q <= live_active_d;
    end
  end

  assign state       = state_q;
  assign note        = note_q;
  assign busy        = busy_q;
  assign step_idx    = step_idx_q;
  assign live_active = live_active_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: the melody is expanded into timed
// play/gap segments and a live key simply pauses progress through them.
module tb_note_sequencer;

  localparam int BEAT_DIV = 4;
  localparam int GAP_DIV  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] key_layer = 3'b000;
  logic [3:0] key_note = 4'b0000;
  logic [2:0] state;
  logic [3:0] note;
  logic       busy;
  logic [3:0] step_idx;
  logic       live_active;

  note_sequencer #(.BEAT_DIV(BEAT_DIV), .GAP_DIV(GAP_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .key_layer(key_layer),
    .key_note(key_note),
    .state(state),
    .note(note),
    .busy(busy),
    .step_idx(step_idx),
    .live_active(live_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] layer;
    logic [3:0] note;
    logic       busy;
    logic [3:0] step;
    logic       live;
    logic       tally;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;
  int cnt_n1, cnt_n8, cnt_live, cnt_gap, cnt_quiet;

  // Reference melody and its expansion into (layer, note, length) segments
  logic [10:0] melody [16];
  logic [2:0]  seg_layer[$];
  logic [3:0]  seg_note[$];
  int          seg_len[$];

  logic m_playing, m_held, m_armed;
  int   m_seg, m_done;

  task automatic buildSegments();
    for (int i = 0; i < 16; i++) melody[i] = 11'd0;
    melody[0] = {3'b001, 4'b0001, 4'd2};
    melody[1] = {3'b010, 4'b1000, 4'd1};
    for (int i = 0; i < 16; i++) begin
      if (melody[i][3:0] == 4'd0) break;
      seg_layer.push_back(melody[i][10:8]);
      seg_note.push_back(melody[i][7:4]);
      seg_len.push_back(int'(melody[i][3:0]) * BEAT_DIV);
      seg_layer.push_back(melody[i][10:8]);
      seg_note.push_back(4'b0000);
      seg_len.push_back(GAP_DIV);
    end
    m_playing = 1'b0;
    m_held    = 1'b0;
    m_armed   = 1'b1;
    m_seg     = 0;
    m_done    = 0;
  endtask

  task automatic modelStep(input logic rst, input logic st, input logic sp,
                           input logic [2:0] kl, input logic [3:0] kn, output exp_t e);
    logic live, was_idle, end_clear;
    live      = ($countones(kn) == 1) && ($countones(kl) == 1);
    was_idle  = !m_playing;
    end_clear = 1'b0;
    e         = '0;
    if (rst) begin
      m_playing = 1'b0;
      m_held    = 1'b0;
      m_armed   = 1'b1;
      m_seg     = 0;
      m_done    = 0;
      return;
    end
    if (m_playing && sp) begin
      m_playing = 1'b0;
      m_held    = 1'b0;
      m_seg     = 0;
      m_done    = 0;
    end else if (!m_playing) begin
      if (st && !sp && m_armed && seg_len.size() > 0) begin
        m_playing = 1'b1;
        m_seg     = 0;
        m_done    = 0;
      end
    end else if (m_held) begin
      if (!live) m_held = 1'b0;
    end else begin
      m_done++;
      if (m_done == seg_len[m_seg]) begin
        m_done = 0;
        m_seg++;
        if (m_seg == seg_len.size()) begin
          m_seg = 0;
`ifndef SEQ_LOOP_EN
          m_playing = 1'b0;
          end_clear = 1'b1;
`endif
        end
      end
      if (m_playing && live) m_held = 1'b1;
    end
    if (end_clear) m_armed = !st;
    else if (!st) m_armed = 1'b1;

    if (!m_playing) begin
      if (was_idle && live) begin
        e.layer = kl;
        e.note  = kn;
        e.live  = 1'b1;
      end
    end else if (m_held) begin
      e.layer = kl;
      e.note  = kn;
      e.busy  = 1'b1;
      e.step  = 4'(m_seg / 2);
      e.live  = 1'b1;
    end else begin
      e.layer = seg_layer[m_seg];
      e.note  = seg_note[m_seg];
      e.busy  = 1'b1;
      e.step  = 4'(m_seg / 2);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic sp,
                               input logic [2:0] kl, input logic [3:0] kn, input logic tl);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    start     = st;
    stop      = sp;
    key_layer = kl;
    key_note  = kn;
    modelStep(rst, st, sp, kl, kn, e);
    e.tally = tl;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    tests++;
    if ({state, note, busy, step_idx, live_active} !== {e.layer, e.note, e.busy, e.step, e.live}) begin
      fails++;
      $display("[TB] FAIL outputs @%0t: got state=%b note=%b busy=%b step=%0d live=%b, expected state=%b note=%b busy=%b step=%0d live=%b",
               $time, state, note, busy, step_idx, live_active, e.layer, e.note, e.busy, e.step, e.live);
    end
    if (e.tally) begin
      if (note == 4'b0001 && state == 3'b001 && !live_active) cnt_n1++;
      if (note == 4'b1000 && state == 3'b010 && !live_active) cnt_n8++;
      if (note == 4'b0100 && state == 3'b100 && live_active) cnt_live++;
      if (busy && note == 4'b0000 && !live_active) cnt_gap++;
      if (!busy && note == 4'b0000 && state == 3'b000 && !live_active) cnt_quiet++;
    end
  endtask

  task automatic checkCount(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic clearTally();
    cnt_n1 = 0; cnt_n8 = 0; cnt_live = 0; cnt_gap = 0; cnt_quiet = 0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput(mon_e);
      end
    end
  end

  logic       r_rst, r_st, r_sp;
  logic [2:0] b_layer;
  logic [3:0] b_note;
  int         burst;

  initial begin
    clearTally();
    buildSegments();

    repeat (3) applyStimulus(1, 0, 0, 3'b000, 4'b0000, 1);
    checkCount("reset_quiet", cnt_quiet, 2);

    // Full melody from a one-cycle start pulse
    clearTally();
    applyStimulus(0, 1, 0, 3'b000, 4'b0000, 1);
    repeat (15) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 1);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 1);
    checkCount("melody_note1", cnt_n1, 8);
    checkCount("melody_note8", cnt_n8, 4);
    checkCount("melody_gaps", cnt_gap, 4);
    clearTally();
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
`ifdef SEQ_LOOP_EN
    checkCount("loop_replay", cnt_n1, 1);
`else
    checkCount("end_idle", cnt_quiet, 1);
`endif
    clearTally();
    applyStimulus(0, 0, 1, 3'b000, 4'b0000, 1);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
    checkCount("stop_idle", cnt_quiet, 1);

    // Live key pauses step 0 and the rest of the step plays after release
    applyStimulus(1, 0, 0, 3'b000, 4'b0000, 0);
    clearTally();
    applyStimulus(0, 1, 0, 3'b000, 4'b0000, 1);
    repeat (2) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 1);
    repeat (5) applyStimulus(0, 0, 0, 3'b100, 4'b0100, 1);
    repeat (5) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 1);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
    checkCount("hold_live", cnt_live, 5);
    checkCount("hold_resume", cnt_n1, 8);

    // Invalid key combinations in IDLE
    applyStimulus(1, 0, 0, 3'b000, 4'b0000, 0);
    clearTally();
    repeat (4) applyStimulus(0, 0, 0, 3'b001, 4'b0011, 1);
    repeat (4) applyStimulus(0, 0, 0, 3'b011, 4'b0100, 1);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
    checkCount("invalid_keys", cnt_quiet, 8);

    // Start and stop together, then reset mid-play
    clearTally();
    repeat (3) applyStimulus(0, 1, 1, 3'b000, 4'b0000, 1);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
    checkCount("start_stop", cnt_quiet, 3);
    applyStimulus(0, 1, 0, 3'b000, 4'b0000, 0);
    repeat (2) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
    clearTally();
    applyStimulus(1, 1, 0, 3'b100, 4'b0100, 1);
    applyStimulus(0, 0, 0, 3'b000, 4'b0000, 0);
    checkCount("reset_midplay", cnt_quiet, 1);

    // Randomized traffic
    burst = 0;
    b_layer = 3'b000;
    b_note = 4'b0000;
    for (int c = 0; c < 2500; c++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 7) == 0);
      r_sp  = ($urandom_range(0, 59) == 0);
      if (burst == 0 && $urandom_range(0, 29) == 0) begin
        burst = $urandom_range(1, 8);
        if ($urandom_range(0, 3) != 0) begin
          b_layer = 3'b001 << $urandom_range(0, 2);
          b_note  = 4'b0001 << $urandom_range(0, 3);
        end else begin
          b_layer = 3'($urandom);
          b_note  = 4'($urandom);
        end
      end
      if (burst > 0) begin
        burst--;
        applyStimulus(r_rst, r_st, r_sp, b_layer, b_note, 0);
      end else begin
        applyStimulus(r_rst, r_st, r_sp, 3'b000, 4'b0000, 0);
      end
    end

    @(posedge clk);
    #2;
    checkCount("queue_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
